alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_decode.sv | 46 ++++
 rtl/alu_issue.sv | 165 ++++++++++++++++
 tb/tb_alu_issue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, alu_op class enum, issue FSM states.
// Used by the issue stage, the op decoder and the ALU itself.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0111;
    localparam logic [OP_W-1:0] OP_EQ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLT = 4'b1100;
    localparam logic [OP_W-1:0] OP_SRA = 4'b1110;
    localparam logic [OP_W-1:0] OP_SRL = 4'b1111;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_ARITH  = 2'b10,
        CLS_UPPER  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } issue_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode from alu_op class and funct fields.
// Ports: alu_op_i, funct3_i, funct7_b5_i, is_rtype_i -> op_o, illegal_o.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic            funct7_b5_i,
    input  logic            is_rtype_i,
    output logic [OP_W-1:0] op_o,
    output logic            illegal_o
);

    alu_op_e cls;

    assign cls = alu_op_e'(alu_op_i);

    always_comb begin
        op_o      = OP_ADD;
        illegal_o = 1'b0;
        unique case (cls)
            CLS_MEM, CLS_UPPER: op_o = OP_ADD;
            CLS_BRANCH: begin
                unique case (funct3_i)
                    3'b000, 3'b001: op_o = OP_EQ;
                    3'b100, 3'b101: op_o = OP_SLT;
                    default:        illegal_o = 1'b1;
                endcase
            end
            CLS_ARITH: begin
                unique case (funct3_i)
                    // immediate forms never subtract, even with bit 30 set
                    3'b000: op_o = (is_rtype_i && funct7_b5_i) ? OP_SUB : OP_ADD;
                    3'b001: op_o = OP_SLL;
                    3'b010: op_o = OP_SLT;
                    3'b011: illegal_o = 1'b1;
                    3'b100: op_o = OP_XOR;
                    3'b101: op_o = funct7_b5_i ? OP_SRA : OP_SRL;
                    3'b110: op_o = OP_OR;
                    3'b111: op_o = OP_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the op, selects operands, registers them behind a
// valid/ready handshake with a one-entry skid buffer (1-cycle latency).
// Ports: clk, reset (sync, active-high); in_valid/in_ready upstream;
// alu_op, funct3, funct7_b5, is_rtype, alu_src, rs*_addr, rs*_data, imm in;
// fwd_valid/fwd_rd/fwd_data writeback bypass (used only with ALU_ISSUE_FWD_EN);
// out_valid/out_ready downstream; SrcA, SrcB, Operation, illegal out.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               alu_op,
    input  logic [2:0]               funct3,
    input  logic                     funct7_b5,
    input  logic                     is_rtype,
    input  logic                     alu_src,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     fwd_valid,
    input  logic [4:0]               fwd_rd,
    input  logic [DATA_WIDTH-1:0]    fwd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_RST = OPCODE_LENGTH'(OP_ADD);

    logic [OP_W-1:0]       dec_op;
    logic                  dec_ill;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  accept;

    issue_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]    out_a_q, out_a_d;
    logic [DATA_WIDTH-1:0]    out_b_q, out_b_d;
    logic [OPCODE_LENGTH-1:0] out_op_q, out_op_d;
    logic                     out_ill_q, out_ill_d;
    logic [DATA_WIDTH-1:0]    skid_a_q, skid_a_d;
    logic [DATA_WIDTH-1:0]    skid_b_q, skid_b_d;
    logic [OPCODE_LENGTH-1:0] skid_op_q, skid_op_d;
    logic                     skid_ill_q, skid_ill_d;

    alu_op_decode u_dec (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7_b5_i(funct7_b5),
        .is_rtype_i (is_rtype),
        .op_o       (dec_op),
        .illegal_o  (dec_ill)
    );

`ifdef ALU_ISSUE_FWD_EN
    // x0 is never forwarded; imm is untouched by the rs2 bypass
    assign rs1_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs1_addr)
                   ? fwd_data : rs1_data;
    assign rs2_val = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs2_addr)
                   ? fwd_data : rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr, rs2_addr};
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    assign in_a     = rs1_val;
    assign in_b     = alu_src ? imm : rs2_val;
    assign in_ready = !reset && (state_q != ST_SKID);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        out_op_d   = out_op_q;
        out_ill_d  = out_ill_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
        skid_op_d  = skid_op_q;
        skid_ill_d = skid_ill_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_a_d   = in_a;
                    out_b_d   = in_b;
                    out_op_d  = OPCODE_LENGTH'(dec_op);
                    out_ill_d = dec_ill;
                    state_d   = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && !out_ready) begin
                    skid_a_d   = in_a;
                    skid_b_d   = in_b;
                    skid_op_d  = OPCODE_LENGTH'(dec_op);
                    skid_ill_d = dec_ill;
                    state_d    = ST_SKID;
                end else if (accept) begin
                    out_a_d   = in_a;
                    out_b_d   = in_b;
                    out_op_d  = OPCODE_LENGTH'(dec_op);
                    out_ill_d = dec_ill;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    out_a_d   = skid_a_q;
                    out_b_d   = skid_b_q;
                    out_op_d  = skid_op_q;
                    out_ill_d = skid_ill_q;
                    state_d   = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_op_q   <= OP_RST;
            out_ill_q  <= 1'b0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_op_q  <= OP_RST;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_op_q   <= out_op_d;
            out_ill_q  <= out_ill_d;
            skid_a_q   <= skid_a_d;
            skid_b_q   <= skid_b_d;
            skid_op_q  <= skid_op_d;
            skid_ill_q <= skid_ill_d;
        end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign SrcA      = out_a_q;
    assign SrcB      = out_b_q;
    assign Operation = out_op_q;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        is_rtype;
    logic        alu_src;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        illegal;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } item_t;

    item_t q[$];

    alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5),
        .is_rtype(is_rtype), .alu_src(alu_src),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] c, input logic [2:0] f3,
                                       input logic f7, input logic rt,
                                       output logic [3:0] op, output logic ill);
        op  = 4'b0010;
        ill = 1'b0;
        if (c == 2'b01) begin
            if (f3 == 3'd0 || f3 == 3'd1)      op = 4'b1000;
            else if (f3 == 3'd4 || f3 == 3'd5) op = 4'b1100;
            else                               ill = 1'b1;
        end else if (c == 2'b10) begin
            case (f3)
                3'd0: op = (rt && f7) ? 4'b0110 : 4'b0010;
                3'd1: op = 4'b0111;
                3'd2: op = 4'b1100;
                3'd3: ill = 1'b1;
                3'd4: op = 4'b0101;
                3'd5: op = f7 ? 4'b1110 : 4'b1111;
                3'd6: op = 4'b0001;
                default: op = 4'b0000;
            endcase
        end
    endfunction

    function automatic item_t ref_item();
        item_t it;
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = rs1_data;
        r2 = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd != 0 && fwd_rd == rs1_addr) r1 = fwd_data;
        if (fwd_valid && fwd_rd != 0 && fwd_rd == rs2_addr) r2 = fwd_data;
`endif
        it.a = r1;
        it.b = alu_src ? imm : r2;
        ref_decode(alu_op, funct3, funct7_b5, is_rtype, it.op, it.ill);
        return it;
    endfunction

    // Reference: items in flight live in a queue; capacity is two.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            bit acc;
            acc = in_valid && (q.size() < 2);
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(ref_item());
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(!reset && q.size() < 2));
            if (q.size() > 0 && out_valid) begin
                check("SrcA", 64'(SrcA), 64'(q[0].a));
                check("SrcB", 64'(SrcB), 64'(q[0].b));
                check("Operation", 64'(Operation), 64'(q[0].op));
                check("illegal", 64'(illegal), 64'(q[0].ill));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'd0;
        funct7_b5 = 1'b0;
        is_rtype  = 1'b0;
        alu_src   = 1'b0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        imm       = 32'd0;
        fwd_valid = 1'b0;
        fwd_rd    = 5'd0;
        fwd_data  = 32'd0;
    endtask

    initial begin
        logic [3:0] mop;
        logic       mill;

        ref_decode(2'b10, 3'd0, 1'b1, 1'b1, mop, mill);
        check("model_sub", 64'(mop), 64'h6);
        ref_decode(2'b01, 3'd2, 1'b0, 1'b0, mop, mill);
        check("model_br_ill", 64'({mop, mill}), 64'h5);

        idle();
        reset     = 1'b1;
        out_ready = 1'b1;
        cyc();
        started = 1'b1;
        cyc();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_op", 64'(Operation), 64'h2);
        check("rst_srca", 64'(SrcA), 64'd0);
        check("rst_srcb", 64'(SrcB), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // immediate with bit 30 set stays ADD
        in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd0; funct7_b5 = 1'b1;
        is_rtype = 1'b0; alu_src = 1'b1; imm = 32'd5; rs2_data = 32'h77;
        cyc();
        check("addi_op", 64'(Operation), 64'h2);
        check("addi_srcb", 64'(SrcB), 64'd5);
        check("addi_ill", 64'(illegal), 64'd0);

        funct3 = 3'd5; is_rtype = 1'b1; alu_src = 1'b0;
        cyc();
        check("sra_op", 64'(Operation), 64'he);
        funct3 = 3'd3;
        cyc();
        check("f3_011_op", 64'(Operation), 64'h2);
        check("f3_011_ill", 64'(illegal), 64'd1);

        idle();
        cyc();
        cyc();

        // A, B, C with a stall starting right after A
        in_valid = 1'b1; rs1_data = 32'hA;
        cyc();
        rs1_data = 32'hB; out_ready = 1'b0;
        cyc();
        check("skid_hold_a", 64'(SrcA), 64'hA);
        check("skid_in_ready", 64'(in_ready), 64'd0);
        rs1_data = 32'hC;
        cyc();
        check("stall_hold_a", 64'(SrcA), 64'hA);
        check("stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cyc();
        check("release_b", 64'(SrcA), 64'hB);
        cyc();
        check("release_c", 64'(SrcA), 64'hC);
        in_valid = 1'b0;
        cyc();
        check("drained", 64'(out_valid), 64'd0);

        // reset while two items are held
        out_ready = 1'b0; in_valid = 1'b1; rs1_data = 32'h11;
        cyc();
        rs1_data = 32'h22;
        cyc();
        check("skid_full", 64'(in_ready), 64'd0);
        reset = 1'b1; in_valid = 1'b0;
        cyc();
        check("rst_skid_valid", 64'(out_valid), 64'd0);
        check("rst_skid_op", 64'(Operation), 64'h2);
        check("rst_skid_ready", 64'(in_ready), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_skid_after", 64'(in_ready), 64'd1);

        // forwarding on rs1
        idle();
        in_valid = 1'b1; rs1_addr = 5'd7; rs1_data = 32'd1;
        fwd_valid = 1'b1; fwd_rd = 5'd7; fwd_data = 32'hDEAD;
        cyc();
`ifdef ALU_ISSUE_FWD_EN
        check("fwd_hit", 64'(SrcA), 64'hDEAD);
`else
        check("fwd_ignored", 64'(SrcA), 64'd1);
`endif
        fwd_rd = 5'd0;
        cyc();
        check("fwd_x0", 64'(SrcA), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 249) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            alu_op    = 2'($urandom_range(0, 3));
            funct3    = 3'($urandom_range(0, 7));
            funct7_b5 = 1'($urandom_range(0, 1));
            is_rtype  = 1'($urandom_range(0, 1));
            alu_src   = 1'($urandom_range(0, 1));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            imm       = $urandom;
            fwd_valid = 1'($urandom_range(0, 1));
            fwd_rd    = 5'($urandom_range(0, 7));
            fwd_data  = $urandom;
            cyc();
        end

        idle();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        check("final_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
